// File: rtl/execute_pkg.sv
// Shared execute-stage definitions: flag bit positions, condition-code
// encodings and the branch-judge output-stage states.
package execute_pkg;

  localparam int FLAG_W = 5;
  localparam int CC_W   = 4;

  localparam int FLAG_ZF = 0;
  localparam int FLAG_PF = 1;
  localparam int FLAG_CF = 2;
  localparam int FLAG_OF = 3;
  localparam int FLAG_SF = 4;

  typedef enum logic [CC_W-1:0] {
    CC_AL = 4'd0,
    CC_EQ = 4'd1,
    CC_NE = 4'd2,
    CC_MI = 4'd3,
    CC_PL = 4'd4,
    CC_VS = 4'd5,
    CC_VC = 4'd6,
    CC_CS = 4'd7,
    CC_CC = 4'd8,
    CC_HI = 4'd9,
    CC_LS = 4'd10,
    CC_GE = 4'd11,
    CC_LT = 4'd12,
    CC_GT = 4'd13,
    CC_LE = 4'd14,
    CC_PE = 4'd15
  } cc_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } judge_state_e;

  // Mispredict is simply disagreement between the resolved and predicted direction.
  function automatic logic calc_mispredict(input logic taken, input logic pred_taken);
    return taken ^ pred_taken;
  endfunction

endpackage

// File: rtl/execute_branch_cond_eval.sv
// Combinational condition-code evaluator; shared with predicated-execution logic.
module execute_branch_cond_eval
  import execute_pkg::*;
(
  input  logic [CC_W-1:0]   iCC,
  input  logic [FLAG_W-1:0] iFLAG,
  output logic              oTRUE
);

  logic zf;
  logic pf;
  logic cf;
  logic of;
  logic sf;

  assign zf = iFLAG[FLAG_ZF];
  assign pf = iFLAG[FLAG_PF];
  assign cf = iFLAG[FLAG_CF];
  assign of = iFLAG[FLAG_OF];
  assign sf = iFLAG[FLAG_SF];

  always_comb begin
    oTRUE = 1'b0;
    case (iCC)
      CC_AL: oTRUE = 1'b1;
      CC_EQ: oTRUE = zf;
      CC_NE: oTRUE = !zf;
      CC_MI: oTRUE = sf;
      CC_PL: oTRUE = !sf;
      CC_VS: oTRUE = of;
      CC_VC: oTRUE = !of;
      CC_CS: oTRUE = cf;
      CC_CC: oTRUE = !cf;
      CC_HI: oTRUE = cf && !zf;
      CC_LS: oTRUE = !cf || zf;
      CC_GE: oTRUE = (sf == of);
      CC_LT: oTRUE = (sf != of);
      CC_GT: oTRUE = !zf && (sf == of);
      CC_LE: oTRUE = zf || (sf != of);
      CC_PE: oTRUE = pf;
      default: oTRUE = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_branch_judge.sv
// Branch judge: resolves a condition code against (bypassed) flags and holds
// the result in a one-entry output stage with valid/busy handshaking.
//
//   state    | meaning
//   ST_EMPTY | no result held, oNEXT_VALID low
//   ST_FULL  | result held on oNEXT_*, waiting for consumer
module execute_branch_judge
  import execute_pkg::*;
#(
  parameter int P_ADDR_W = 32,
  parameter int P_CC_W   = 4
) (
  input  logic                iCLOCK,
  input  logic                inRESET,
  input  logic                iRESET_SYNC,
  input  logic                iFLUSH,
  input  logic [FLAG_W-1:0]   iFLAG,
  input  logic                iFWD_FLAG_VALID,
  input  logic [FLAG_W-1:0]   iFWD_FLAG,
  input  logic                iPREV_VALID,
  output logic                oPREV_BUSY,
  input  logic [P_CC_W-1:0]   iPREV_CC,
  input  logic [P_ADDR_W-1:0] iPREV_TARGET,
  input  logic [P_ADDR_W-1:0] iPREV_NEXT_PC,
  input  logic                iPREV_PRED_TAKEN,
  output logic                oNEXT_VALID,
  input  logic                iNEXT_BUSY,
  output logic                oNEXT_TAKEN,
  output logic [P_ADDR_W-1:0] oNEXT_PC,
  output logic                oNEXT_MISPREDICT
);

  judge_state_e        state_q;
  judge_state_e        state_d;
  logic [FLAG_W-1:0]   flag_eff;
  logic                cond_true;
  logic                accept;
  logic                load;
  logic                taken_q;
  logic [P_ADDR_W-1:0] pc_q;
  logic                mispredict_q;

  // Flags retiring this cycle win over the architectural copy.
  assign flag_eff = iFWD_FLAG_VALID ? iFWD_FLAG : iFLAG;

  execute_branch_cond_eval u_cond_eval (
    .iCC   (iPREV_CC),
    .iFLAG (flag_eff),
    .oTRUE (cond_true)
  );

  assign oNEXT_VALID = (state_q == ST_FULL);
  assign oPREV_BUSY  = oNEXT_VALID && iNEXT_BUSY;
  assign accept      = iPREV_VALID && !oPREV_BUSY;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q <= ST_EMPTY;
    end else if (iRESET_SYNC) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    if (iFLUSH) begin
      state_d = ST_EMPTY;
    end else if (accept) begin
      state_d = ST_FULL;
      load    = 1'b1;
    end else if ((state_q == ST_FULL) && !iNEXT_BUSY) begin
      state_d = ST_EMPTY;
    end
  end

  // Payload only moves on accept, so a stalled result never sees later flags.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      taken_q      <= 1'b0;
      pc_q         <= '0;
      mispredict_q <= 1'b0;
    end else if (iRESET_SYNC) begin
      taken_q      <= 1'b0;
      pc_q         <= '0;
      mispredict_q <= 1'b0;
    end else if (load) begin
      taken_q      <= cond_true;
      pc_q         <= cond_true ? iPREV_TARGET : iPREV_NEXT_PC;
      mispredict_q <= calc_mispredict(cond_true, iPREV_PRED_TAKEN);
    end
  end

  assign oNEXT_TAKEN      = taken_q;
  assign oNEXT_PC         = pc_q;
  assign oNEXT_MISPREDICT = mispredict_q;

endmodule

// File: tb/tb_execute_branch_judge.sv
// Directed bench for execute_branch_judge: transaction-level reference model
// compared every cycle, plus hand-computed literal checks per scenario.
module tb_execute_branch_judge;
  import execute_pkg::*;

  localparam int AW = 32;

  logic          iCLOCK = 1'b0;
  logic          inRESET;
  logic          iRESET_SYNC;
  logic          iFLUSH;
  logic [4:0]    iFLAG;
  logic          iFWD_FLAG_VALID;
  logic [4:0]    iFWD_FLAG;
  logic          iPREV_VALID;
  logic          oPREV_BUSY;
  logic [3:0]    iPREV_CC;
  logic [AW-1:0] iPREV_TARGET;
  logic [AW-1:0] iPREV_NEXT_PC;
  logic          iPREV_PRED_TAKEN;
  logic          oNEXT_VALID;
  logic          iNEXT_BUSY;
  logic          oNEXT_TAKEN;
  logic [AW-1:0] oNEXT_PC;
  logic          oNEXT_MISPREDICT;

  int tests = 0;
  int fails = 0;

  execute_branch_judge #(.P_ADDR_W(AW), .P_CC_W(4)) dut (
    .iCLOCK           (iCLOCK),
    .inRESET          (inRESET),
    .iRESET_SYNC      (iRESET_SYNC),
    .iFLUSH           (iFLUSH),
    .iFLAG            (iFLAG),
    .iFWD_FLAG_VALID  (iFWD_FLAG_VALID),
    .iFWD_FLAG        (iFWD_FLAG),
    .iPREV_VALID      (iPREV_VALID),
    .oPREV_BUSY       (oPREV_BUSY),
    .iPREV_CC         (iPREV_CC),
    .iPREV_TARGET     (iPREV_TARGET),
    .iPREV_NEXT_PC    (iPREV_NEXT_PC),
    .iPREV_PRED_TAKEN (iPREV_PRED_TAKEN),
    .oNEXT_VALID      (oNEXT_VALID),
    .iNEXT_BUSY       (iNEXT_BUSY),
    .oNEXT_TAKEN      (oNEXT_TAKEN),
    .oNEXT_PC         (oNEXT_PC),
    .oNEXT_MISPREDICT (oNEXT_MISPREDICT)
  );

  always #5 iCLOCK = ~iCLOCK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference condition table written from the flag meanings {S,O,C,P,Z}.
  function automatic logic cond_ref(input logic [3:0] cc, input logic [4:0] f);
    logic z, p, c, o, s, lt, hi;
    z  = f[0]; p = f[1]; c = f[2]; o = f[3]; s = f[4];
    lt = (s != o);
    hi = c && !z;
    case (cc)
      4'd0:  return 1'b1;
      4'd1:  return z;
      4'd2:  return !z;
      4'd3:  return s;
      4'd4:  return !s;
      4'd5:  return o;
      4'd6:  return !o;
      4'd7:  return c;
      4'd8:  return !c;
      4'd9:  return hi;
      4'd10: return !hi;
      4'd11: return !lt;
      4'd12: return lt;
      4'd13: return !z && !lt;
      4'd14: return !(!z && !lt);
      default: return p;
    endcase
  endfunction

  // Transaction model: a slot holding at most one resolved branch.
  logic          m_valid;
  logic          m_taken;
  logic [AW-1:0] m_pc;
  logic          m_mis;

  always @(posedge iCLOCK or negedge inRESET) begin
    logic t;
    logic slot_free;
    if (!inRESET || iRESET_SYNC) begin
      m_valid <= 1'b0; m_taken <= 1'b0; m_pc <= '0; m_mis <= 1'b0;
    end else begin
      slot_free = !(m_valid && iNEXT_BUSY);
      if (iFLUSH) begin
        m_valid <= 1'b0;
      end else if (iPREV_VALID && slot_free) begin
        t = cond_ref(iPREV_CC, iFWD_FLAG_VALID ? iFWD_FLAG : iFLAG);
        m_valid <= 1'b1;
        m_taken <= t;
        m_pc    <= t ? iPREV_TARGET : iPREV_NEXT_PC;
        m_mis   <= (t != iPREV_PRED_TAKEN);
      end else if (slot_free) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge iCLOCK) begin
    check("model_valid", {63'd0, oNEXT_VALID}, {63'd0, m_valid});
    check("model_busy", {63'd0, oPREV_BUSY}, {63'd0, m_valid && iNEXT_BUSY});
    if (m_valid) begin
      check("model_taken", {63'd0, oNEXT_TAKEN}, {63'd0, m_taken});
      check("model_pc", {32'd0, oNEXT_PC}, {32'd0, m_pc});
      check("model_mis", {63'd0, oNEXT_MISPREDICT}, {63'd0, m_mis});
    end
  end

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic req(input logic [3:0] cc, input logic [4:0] flag, input logic fwd_v,
                     input logic [4:0] fwd, input logic [AW-1:0] tgt,
                     input logic [AW-1:0] npc, input logic pred);
    iPREV_VALID      = 1'b1;
    iPREV_CC         = cc;
    iFLAG            = flag;
    iFWD_FLAG_VALID  = fwd_v;
    iFWD_FLAG        = fwd;
    iPREV_TARGET     = tgt;
    iPREV_NEXT_PC    = npc;
    iPREV_PRED_TAKEN = pred;
  endtask

  task automatic expect_out(input string name, input logic v, input logic t,
                            input logic [AW-1:0] pc, input logic mis);
    check({name, "_valid"}, {63'd0, oNEXT_VALID}, {63'd0, v});
    check({name, "_taken"}, {63'd0, oNEXT_TAKEN}, {63'd0, t});
    check({name, "_pc"}, {32'd0, oNEXT_PC}, {32'd0, pc});
    check({name, "_mis"}, {63'd0, oNEXT_MISPREDICT}, {63'd0, mis});
  endtask

  logic [3:0]  b2b_cc   [4];
  logic [4:0]  b2b_flag [4];
  logic        b2b_pred [4];
  logic        b2b_take [4];

  initial begin
    inRESET = 1'b0; iRESET_SYNC = 1'b0; iFLUSH = 1'b0; iNEXT_BUSY = 1'b0;
    req(CC_AL, 5'h00, 1'b0, 5'h00, 32'h100, 32'h104, 1'b0);

    // Reset with a request pending
    repeat (3) tick();
    expect_out("reset", 1'b0, 1'b0, 32'h0, 1'b0);
    check("reset_busy", {63'd0, oPREV_BUSY}, 64'd0);
    inRESET = 1'b1;
    tick();
    expect_out("first_al", 1'b1, 1'b1, 32'h100, 1'b1);

    // Bypass
    req(CC_EQ, 5'h00, 1'b1, 5'h01, 32'h200, 32'h204, 1'b1);
    tick();
    expect_out("bypass_on", 1'b1, 1'b1, 32'h200, 1'b0);
    iFWD_FLAG_VALID = 1'b0;
    tick();
    expect_out("bypass_off", 1'b1, 1'b0, 32'h204, 1'b1);

    // Signed condition codes
    req(CC_LT, 5'h10, 1'b0, 5'h00, 32'h300, 32'h304, 1'b0);
    tick();
    expect_out("lt", 1'b1, 1'b1, 32'h300, 1'b1);
    req(CC_GT, 5'h18, 1'b0, 5'h00, 32'h400, 32'h404, 1'b1);
    tick();
    expect_out("gt_t", 1'b1, 1'b1, 32'h400, 1'b0);
    req(CC_GT, 5'h01, 1'b0, 5'h00, 32'h500, 32'h504, 1'b0);
    tick();
    expect_out("gt_nt", 1'b1, 1'b0, 32'h504, 1'b0);

    // Back-pressure: hold 0x504 result, request B waits on PREV
    iNEXT_BUSY = 1'b1;
    req(CC_NE, 5'h00, 1'b0, 5'h00, 32'h600, 32'h604, 1'b0);
    #1 check("bp_busy0", {63'd0, oPREV_BUSY}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      iFLAG = 5'h1f;
      tick();
      expect_out("bp_hold", 1'b1, 1'b0, 32'h504, 1'b0);
      check("bp_busy", {63'd0, oPREV_BUSY}, 64'd1);
    end
    iNEXT_BUSY = 1'b0;
    iFLAG = 5'h00;
    #1 check("bp_release_busy", {63'd0, oPREV_BUSY}, 64'd0);
    tick();
    expect_out("bp_accept", 1'b1, 1'b1, 32'h600, 1'b1);

    // Back-to-back, no bubbles
    b2b_cc   = '{CC_HI, CC_LS, CC_PE, CC_VS};
    b2b_flag = '{5'b00100, 5'b00100, 5'b00010, 5'b01000};
    b2b_pred = '{1'b1, 1'b1, 1'b0, 1'b1};
    b2b_take = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      req(b2b_cc[i], b2b_flag[i], 1'b0, 5'h00, 32'h1000 + 32'(i * 16),
          32'h1004 + 32'(i * 16), b2b_pred[i]);
      tick();
      expect_out("b2b", 1'b1, b2b_take[i],
                 b2b_take[i] ? 32'h1000 + 32'(i * 16) : 32'h1004 + 32'(i * 16),
                 b2b_take[i] != b2b_pred[i]);
    end
    iPREV_VALID = 1'b0;
    tick();
    check("b2b_drain", {63'd0, oNEXT_VALID}, 64'd0);

    // Flush with FULL and a request present
    req(CC_AL, 5'h00, 1'b0, 5'h00, 32'h700, 32'h704, 1'b1);
    tick();
    check("flush_pre", {63'd0, oNEXT_VALID}, 64'd1);
    req(CC_AL, 5'h00, 1'b0, 5'h00, 32'h800, 32'h804, 1'b1);
    iFLUSH = 1'b1;
    tick();
    check("flush_v0", {63'd0, oNEXT_VALID}, 64'd0);
    iFLUSH = 1'b0;
    iPREV_VALID = 1'b0;
    tick();
    check("flush_v1", {63'd0, oNEXT_VALID}, 64'd0);
    check("flush_pc", {32'd0, oNEXT_PC}, {32'd0, 32'h700});

    // Async reset mid-stall
    req(CC_AL, 5'h00, 1'b0, 5'h00, 32'h900, 32'h904, 1'b0);
    tick();
    iNEXT_BUSY = 1'b1;
    req(CC_AL, 5'h00, 1'b0, 5'h00, 32'hA00, 32'hA04, 1'b0);
    tick();
    expect_out("stall", 1'b1, 1'b1, 32'h900, 1'b1);
    inRESET = 1'b0;
    #1 expect_out("async_rst", 1'b0, 1'b0, 32'h0, 1'b0);
    iPREV_VALID = 1'b0;
    tick();
    inRESET = 1'b1;
    iNEXT_BUSY = 1'b0;
    tick();
    check("async_rst_after", {63'd0, oNEXT_VALID}, 64'd0);

    // Synchronous reset with a request present
    req(CC_AL, 5'h00, 1'b0, 5'h00, 32'hB00, 32'hB04, 1'b0);
    tick();
    check("sync_pre", {32'd0, oNEXT_PC}, {32'd0, 32'hB00});
    req(CC_AL, 5'h00, 1'b0, 5'h00, 32'hC00, 32'hC04, 1'b0);
    iRESET_SYNC = 1'b1;
    tick();
    expect_out("sync_rst", 1'b0, 1'b0, 32'h0, 1'b0);
    iRESET_SYNC = 1'b0;
    iPREV_VALID = 1'b0;
    tick();
    check("sync_after", {63'd0, oNEXT_VALID}, 64'd0);

    @(negedge iCLOCK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
